// File: rtl/im2col_stream.sv
// Streaming im2col: buffers K image rows in a ring of line slots and presents one
// row of KxK patches (one per output column) per handshake.
module im2col_stream #(
  parameter int DW     = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  localparam int OUT_W = (IMG_W - K) / STRIDE + 1,
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1,
  localparam int RIW   = (OUT_H > 1) ? $clog2(OUT_H) : 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_pre_valid,
  output logic                              o_pre_ready,
  input  logic [IMG_W-1:0][DW-1:0]          i_data,
  output logic                              o_post_valid,
  input  logic                              i_post_ready,
  output logic [OUT_W-1:0][K*K-1:0][DW-1:0] o_data,
  output logic [RIW-1:0]                    o_row_idx,
  output logic                              o_frame_last
);

  localparam int RCW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int SW  = (K > 1) ? $clog2(K) : 1;
  localparam int SW1 = SW + 1;
  localparam int SMK = STRIDE % K;

  typedef enum logic [1:0] {FILL, OUT, SKIP} state_t;

  state_t                   state;
  logic [RIW-1:0]           r;
  logic [RCW-1:0]           row_cnt;
  logic [RCW-1:0]           win_last;
  logic [SW-1:0]            slot;
  logic [SW-1:0]            base;
  logic [IMG_W-1:0][DW-1:0] line_buf [K];

  logic          pre_fire;
  logic          post_fire;
  logic          row_is_last;
  logic          r_is_last;
  logic [SW-1:0] slot_next;
  logic [SW:0]   base_sum;
  logic [SW-1:0] base_next;

  // Handshake outputs are decoded from the state register and forced low in reset.
  assign o_pre_ready  = (state != OUT) && !i_rst;
  assign o_post_valid = (state == OUT) && !i_rst;
  assign o_row_idx    = i_rst ? '0 : r;
  assign o_frame_last = o_post_valid && r_is_last;

  assign pre_fire    = i_pre_valid && o_pre_ready;
  assign post_fire   = o_post_valid && i_post_ready;
  assign row_is_last = (row_cnt == RCW'(IMG_H - 1));
  assign r_is_last   = (r == RIW'(OUT_H - 1));
  assign slot_next   = (slot == SW'(K - 1)) ? '0 : slot + 1'b1;

  // The window base advances by STRIDE mod K, so one conditional subtract wraps it.
  assign base_sum  = {1'b0, base} + SW1'(SMK);
  assign base_next = (base_sum >= SW1'(K)) ? SW'(base_sum - SW1'(K)) : SW'(base_sum);

  // NOTE: every register here is assigned with <= so all branches see pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= FILL;
      r        <= '0;
      row_cnt  <= '0;
      win_last <= RCW'(K - 1);
      slot     <= '0;
      base     <= '0;
    end else begin
      case (state)
        FILL: if (pre_fire) begin
          slot    <= slot_next;
          row_cnt <= row_is_last ? '0 : row_cnt + 1'b1;
          if (row_cnt == win_last) state <= OUT;
        end
        OUT: if (post_fire) begin
          if (r_is_last) begin
            r        <= '0;
            base     <= '0;
            win_last <= RCW'(K - 1);
            // A wrapped row counter means the frame's last row is already in.
            if (row_cnt == '0) begin
              state <= FILL;
              slot  <= '0;
            end else begin
              state <= SKIP;
            end
          end else begin
            r        <= r + 1'b1;
            base     <= base_next;
            win_last <= win_last + RCW'(STRIDE);
            state    <= FILL;
          end
        end
        SKIP: if (pre_fire) begin
          if (row_is_last) begin
            row_cnt <= '0;
            slot    <= '0;
            state   <= FILL;
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // NOTE: the line buffer is storage only, so it has no reset; stale rows are never read
  // because a window is presented only after all K of its rows have been rewritten.
  always_ff @(posedge i_clk) begin
    if (state == FILL && pre_fire) line_buf[slot] <= i_data;
  end

  for (genvar ki = 0; ki < K; ki++) begin : g_win_row
    logic [SW:0]   rd_sum;
    logic [SW-1:0] rd_slot;
    assign rd_sum  = {1'b0, base} + SW1'(ki);
    assign rd_slot = (rd_sum >= SW1'(K)) ? SW'(rd_sum - SW1'(K)) : SW'(rd_sum);
    for (genvar c = 0; c < OUT_W; c++) begin : g_col
      for (genvar kj = 0; kj < K; kj++) begin : g_tap
        assign o_data[c][ki*K+kj] = line_buf[rd_slot][c*STRIDE+kj];
      end
    end
  end

endmodule

// File: tb/tb_im2col_stream.sv
// Bench for im2col_stream: a window-count model of the 28x28/K3/S1 instance checked
// every cycle, plus directed frames on an 8x8/K3/S2 instance.
module tb_im2col_stream;

  localparam int A_W = 28, A_H = 28, A_K = 3, A_S = 1, A_OW = 26, A_OH = 26;
  localparam int B_W = 8,  B_H = 8,  B_K = 3, B_S = 2, B_OW = 3,  B_OH = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                            a_rst, a_pre_valid, a_pre_ready, a_post_valid, a_post_ready, a_frame_last;
  logic [A_W-1:0][7:0]             a_idata;
  logic [A_OW-1:0][A_K*A_K-1:0][7:0] a_odata;
  logic [4:0]                      a_row_idx;

  logic                            b_rst, b_pre_valid, b_pre_ready, b_post_valid, b_post_ready, b_frame_last;
  logic [B_W-1:0][7:0]             b_idata;
  logic [B_OW-1:0][B_K*B_K-1:0][7:0] b_odata;
  logic [1:0]                      b_row_idx;

  im2col_stream dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_pre_valid(a_pre_valid), .o_pre_ready(a_pre_ready),
    .i_data(a_idata), .o_post_valid(a_post_valid), .i_post_ready(a_post_ready),
    .o_data(a_odata), .o_row_idx(a_row_idx), .o_frame_last(a_frame_last)
  );

  im2col_stream #(.DW(8), .IMG_W(B_W), .IMG_H(B_H), .K(B_K), .STRIDE(B_S)) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_pre_valid(b_pre_valid), .o_pre_ready(b_pre_ready),
    .i_data(b_idata), .o_post_valid(b_post_valid), .i_post_ready(b_post_ready),
    .o_data(b_odata), .o_row_idx(b_row_idx), .o_frame_last(b_frame_last)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int pix(input int f, input int n, input int c);
    return (n * 28 + c + f * 100) & 255;
  endfunction

  // Reference model: a window is due once enough rows of the frame have arrived.
  logic [7:0] img [A_H][A_W];
  int  rows_in = 0, outs_done = 0, frames_done = 0, fires = 0, cyc = 0, last_fire = 0;
  bit  gap_mode = 1'b0;
  bit  pend;
  int  bad_c, bad_k, bad_exp;

  always @(negedge clk) begin
    cyc++;
    if (a_rst) begin
      check("rst_pre_ready", int'(a_pre_ready), 0);
      check("rst_post_valid", int'(a_post_valid), 0);
      check("rst_row_idx", int'(a_row_idx), 0);
      check("rst_frame_last", int'(a_frame_last), 0);
      rows_in   = 0;
      outs_done = 0;
    end else begin
      pend = (outs_done < A_OH) && (rows_in >= outs_done * A_S + A_K);
      check("post_valid", int'(a_post_valid), int'(pend));
      check("pre_ready", int'(a_pre_ready), int'(!pend));
      if (pend) begin
        check("row_idx", int'(a_row_idx), outs_done);
        check("frame_last", int'(a_frame_last), int'(outs_done == A_OH - 1));
        bad_c = -1; bad_k = 0; bad_exp = 0;
        for (int c = 0; c < A_OW; c++)
          for (int ki = 0; ki < A_K; ki++)
            for (int kj = 0; kj < A_K; kj++)
              if (bad_c < 0 && int'(a_odata[c][ki*A_K+kj]) != int'(img[outs_done*A_S+ki][c*A_S+kj])) begin
                bad_c   = c;
                bad_k   = ki * A_K + kj;
                bad_exp = int'(img[outs_done*A_S+ki][c*A_S+kj]);
              end
        if (bad_c < 0) check("patch_data", int'(a_odata[0][0]), int'(img[outs_done*A_S][0]));
        else check($sformatf("patch_data[%0d][%0d]", bad_c, bad_k), int'(a_odata[bad_c][bad_k]), bad_exp);
      end
      if (a_pre_valid && !pend && rows_in < A_H) begin
        for (int c = 0; c < A_W; c++) img[rows_in][c] = a_idata[c];
        rows_in++;
      end
      if (pend && a_post_ready) begin
        if (gap_mode && outs_done > 0) check("out_gap", cyc - last_fire, 2);
        last_fire = cyc;
        outs_done++;
        fires++;
      end
      if (outs_done == A_OH && rows_in == A_H) begin
        rows_in   = 0;
        outs_done = 0;
        frames_done++;
      end
    end
  end

  bit a_acc, a_fire, b_acc, b_fire;

  task automatic tick();
    @(negedge clk);
    a_acc  = a_pre_valid && a_pre_ready;
    a_fire = a_post_valid && a_post_ready;
    b_acc  = b_pre_valid && b_pre_ready;
    b_fire = b_post_valid && b_post_ready;
    @(posedge clk);
    #1;
  endtask

  int drv_row, drv_f;

  task automatic set_row_a();
    for (int c = 0; c < A_W; c++) a_idata[c] = 8'(pix(drv_f, drv_row, c));
  endtask

  task automatic adv_row_a();
    drv_row = (drv_row + 1) % A_H;
    if (drv_row == 0) drv_f++;
    set_row_a();
  endtask

  task automatic set_row_b(input int f, input int n);
    for (int c = 0; c < B_W; c++) b_idata[c] = 8'(pix(f, n, c));
  endtask

  task automatic run_b_frame(input int f);
    int sent, outs, idle, bc, bk, be;
    sent = 0; outs = 0; idle = 0;
    b_post_ready = 1'b1;
    set_row_b(f, 0);
    b_pre_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (b_acc) sent++;
      if (b_fire) outs++;
      if (sent < B_H) set_row_b(f, sent);
      else begin
        b_pre_valid = 1'b0;
        idle++;
      end
      check("b_exclusive", int'(b_pre_ready && b_post_valid), 0);
      if (b_post_valid) begin
        check("b_row_idx", int'(b_row_idx), outs);
        check("b_frame_last", int'(b_frame_last), int'(outs == B_OH - 1));
        bc = -1; bk = 0; be = 0;
        for (int c = 0; c < B_OW; c++)
          for (int ki = 0; ki < B_K; ki++)
            for (int kj = 0; kj < B_K; kj++)
              if (bc < 0 && int'(b_odata[c][ki*B_K+kj]) != pix(f, outs*B_S+ki, c*B_S+kj)) begin
                bc = c; bk = ki * B_K + kj; be = pix(f, outs*B_S+ki, c*B_S+kj);
              end
        if (bc < 0) check("b_patch", int'(b_odata[0][0]), pix(f, outs*B_S, 0));
        else check($sformatf("b_patch[%0d][%0d]", bc, bk), int'(b_odata[bc][bk]), be);
        if (outs == B_OH - 1) begin
          check("b_last_patch[2][8]", int'(b_odata[2][8]), pix(f, 6, 6));
          if (f == 0) check("b_last_patch_literal", int'(b_odata[2][8]), 174);
        end
      end
      if (idle >= 4) break;
    end
    check("b_rows_accepted", sent, B_H);
    check("b_outputs", outs, B_OH);
  endtask

  int lit [9] = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
  logic [A_OW-1:0][A_K*A_K-1:0][7:0] snap;
  int n_acc, f_before;

  initial begin
    a_rst = 1'b1; a_pre_valid = 1'b0; a_post_ready = 1'b0; a_idata = '0;
    b_rst = 1'b1; b_pre_valid = 1'b0; b_post_ready = 1'b0; b_idata = '0;
    drv_row = 0; drv_f = 0;
    repeat (3) tick();
    a_rst = 1'b0;
    b_rst = 1'b0;

    // First window: rows 0..2 back to back, then a 10-cycle downstream stall.
    set_row_a();
    a_pre_valid = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 20 && n_acc < 3; i++) begin
      tick();
      if (a_acc) begin
        n_acc++;
        adv_row_a();
      end
    end
    check("first_fill_rows", n_acc, 3);
    check("first_valid", int'(a_post_valid), 1);
    check("first_row_idx", int'(a_row_idx), 0);
    for (int k = 0; k < 9; k++) check($sformatf("first_patch[0][%0d]", k), int'(a_odata[0][k]), lit[k]);
    check("first_patch[25][8]", int'(a_odata[25][8]), 83);
    snap = a_odata;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_pre_ready", int'(a_pre_ready), 0);
      check("stall_accept", int'(a_acc), 0);
      check("stall_valid", int'(a_post_valid), 1);
      check("stall_data_stable", int'(a_odata == snap), 1);
    end
    gap_mode = 1'b1;
    a_post_ready = 1'b1;
    tick();
    check("stall_release", int'(a_fire), 1);

    // Stream to the end of the second frame with valid and ready held high.
    for (int i = 0; i < 400 && frames_done < 2; i++) begin
      tick();
      if (a_acc) adv_row_a();
    end
    check("two_frames", frames_done, 2);
    check("two_frame_outputs", fires, 2 * A_OH);
    gap_mode = 1'b0;

    // Reset after 10 rows of the third frame, then refill from row 0 with new data.
    n_acc = 0;
    for (int i = 0; i < 60 && n_acc < 10; i++) begin
      tick();
      if (a_acc) begin
        n_acc++;
        adv_row_a();
      end
    end
    check("pre_reset_rows", n_acc, 10);
    a_pre_valid = 1'b0;
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    check("post_reset_valid", int'(a_post_valid), 0);
    drv_row = 0;
    drv_f = 7;
    set_row_a();
    a_pre_valid = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 20 && n_acc < 3; i++) begin
      tick();
      if (a_acc) begin
        n_acc++;
        adv_row_a();
      end
    end
    check("reset_refill_rows", n_acc, 3);
    check("reset_first_valid", int'(a_post_valid), 1);
    check("reset_row_idx", int'(a_row_idx), 0);
    check("reset_patch[0][0]", int'(a_odata[0][0]), pix(7, 0, 0));
    check("reset_patch[1][8]", int'(a_odata[1][8]), pix(7, 2, 3));

    // Random traffic with occasional resets.
    f_before = fires;
    for (int i = 0; i < 3000; i++) begin
      a_pre_valid  = ($urandom_range(3) != 0);
      a_post_ready = ($urandom_range(2) != 0);
      for (int c = 0; c < A_W; c++) a_idata[c] = 8'($urandom);
      a_rst = ($urandom_range(499) == 0);
      tick();
    end
    a_rst = 1'b0;
    a_pre_valid = 1'b0;
    check("random_progress", int'(fires - f_before > 50), 1);

    // Strided instance: two consecutive frames, the second must start at row 0.
    run_b_frame(0);
    run_b_frame(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/im2col_stream.md
IM2COL_STREAM -- requirements
Module: im2col_stream

Interface
REQ-001 The module SHALL have parameters, one per line:
  DW, 8, pixel width in bits
  IMG_W, 28, input image width in pixels
  IMG_H, 28, input image height in rows
  K, 3, square kernel size
  STRIDE, 1, window step in both dimensions
REQ-002 The module SHALL use these derived constants: OUT_W = (IMG_W-K)/STRIDE+1, OUT_H = (IMG_H-K)/STRIDE+1 (integer division); legal only for K>=1, STRIDE>=1, K<=IMG_W, K<=IMG_H.
REQ-003 The module SHALL have ports, one per line:
  i_clk  in  1  single clock, all logic on rising edge
  i_rst  in  1  synchronous, active-high reset
  i_pre_valid  in  1  input row valid
  o_pre_ready  out  1  input row accepted when high together with i_pre_valid
  i_data  in  DW x [IMG_W]  one image row, element c = column c
  o_post_valid  out  1  patch row valid
  i_post_ready  in  1  downstream accepts patch row
  o_data  out  DW x [OUT_W][K*K]  patch row, element [c][ki*K+kj]
  o_row_idx  out  max(1,$clog2(OUT_H))  output row index of current patch row
  o_frame_last  out  1  high with the final patch row (o_row_idx = OUT_H-1) of a frame

Function
REQ-004 The module SHALL accept rows in frame order (input row 0..IMG_H-1); the row counter SHALL wrap to 0 after row IMG_H-1, and the next accepted row SHALL be row 0 of a new frame.
REQ-005 The module SHALL store rows in a K-slot ring line buffer; input row n SHALL be written to slot n mod K; the slot counter SHALL reset to 0 at each frame start.
REQ-006 The module SHALL implement an FSM with states FILL, OUT and SKIP.
REQ-007 FILL: o_pre_ready=1, o_post_valid=0; when the accepted row index equals r*STRIDE+K-1 (r = current output row), the FSM SHALL go to OUT; otherwise it SHALL stay in FILL.
REQ-008 OUT: o_pre_ready=0, o_post_valid=1; the line buffer, o_data, o_row_idx and o_frame_last SHALL remain stable until the output handshake (o_post_valid & i_post_ready).
REQ-009 On the OUT handshake with r<OUT_H-1, the FSM SHALL increment r and return to FILL.
REQ-010 On the OUT handshake with r=OUT_H-1, the FSM SHALL reset r to 0 and go to FILL with the row counter at 0 if row IMG_H-1 was already accepted; otherwise it SHALL go to SKIP.
REQ-011 SKIP: o_pre_ready=1, o_post_valid=0; rows SHALL be accepted and discarded; after accepting row IMG_H-1, the FSM SHALL go to FILL with the row and slot counters at 0.
REQ-012 o_data[c][ki*K+kj] SHALL equal input pixel (row r*STRIDE+ki, column c*STRIDE+kj) of the current frame; window row ki SHALL be read from slot (base+ki) mod K, where base = (r*STRIDE) mod K is tracked incrementally.
REQ-013 o_data SHALL be driven combinationally from the line buffer, and SHALL be defined only while o_post_valid=1.
REQ-014 Latency: if the row completing a window is accepted on edge t, o_post_valid SHALL be high in the cycle following t.
REQ-015 Throughput: with continuous valid and ready and STRIDE=1, the module SHALL sustain one patch row per 2 cycles after the initial fill.
REQ-016 o_pre_ready and o_post_valid SHALL never be high in the same cycle.
REQ-017 No arithmetic SHALL be performed on pixel data; values SHALL pass through bit-exact.

Reset
REQ-018 While i_rst=1: state = FILL; r, row counter, slot counter and base = 0; o_post_valid=0; o_pre_ready=0 (gated by reset); o_row_idx=0; o_frame_last=0.
REQ-019 Reset asserted mid-frame SHALL abandon the partial frame; the first row accepted after reset SHALL be row 0. Line buffer contents need not be cleared.

Verification
REQ-020 Defaults, pixel(n,c)=(n*28+c)&8'hFF, rows 0..2 sent back-to-back -> o_post_valid one cycle after row 2 is accepted; o_row_idx=0; o_data[0] = {0,1,2,28,29,30,56,57,58}; o_data[25][8] = 83.
REQ-021 Defaults, i_post_ready held 0 for 10 cycles while in OUT -> o_pre_ready=0 throughout, o_data unchanged, no row accepted; output completes on the first cycle i_post_ready=1.
REQ-022 IMG_W=IMG_H=8, K=3, STRIDE=2 -> 3 patch rows per frame, the third with o_frame_last=1 and o_data[2][8]=pixel(6,6); row 7 is then accepted in SKIP with no output; the next row is treated as row 0.
REQ-023 Defaults, two frames streamed with i_post_ready=1 -> 26 patch rows per frame; o_frame_last is high only on the 26th; o_row_idx restarts at 0 in frame 2 with correct data; the gap between consecutive outputs is 2 cycles.
REQ-024 Defaults, i_rst pulsed for 1 cycle after 10 rows are accepted -> o_post_valid=0 the following cycle; the first output after reset appears only after 3 new rows, with o_row_idx=0 and data from the new rows.
